// File: rtl/adc_scan_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// adc_scan_pkg
// Shared constants and the state encoding for the ADC channel-scan sequencer.
//   NUM_CH  : number of ADC channels behind the serial reader
//   CH_W    : channel-select width
//   DATA_W  : conversion result width
//   TMO_W   : per-channel timeout counter width
//   TMR_W   : scan period timer width
// ---------------------------------------------------------------------------
package adc_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 12;
    localparam int TMO_W  = 16;
    localparam int TMR_W  = 24;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        CONV,
        STORE
    } scan_state_e;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer_if
// Request/completion handshake between the scan sequencer and the serial
// ADC reader.
//   measure_start    : sequencer -> reader, reader triggers on rising edge
//   measure_ch       : sequencer -> reader, channel select
//   measure_done     : reader -> sequencer, high from end of conversion until
//                      the next start edge
//   measure_dataread : reader -> sequencer, valid while measure_done is high
// Modports: master = sequencer side, slave = reader side.
// ---------------------------------------------------------------------------
interface adc_scan_sequencer_if;
    import adc_scan_pkg::*;

    logic              measure_start;
    logic [CH_W-1:0]   measure_ch;
    logic              measure_done;
    logic [DATA_W-1:0] measure_dataread;

    modport master (
        output measure_start,
        output measure_ch,
        input  measure_done,
        input  measure_dataread
    );

    modport slave (
        input  measure_start,
        input  measure_ch,
        output measure_done,
        output measure_dataread
    );

endinterface

// File: rtl/adc_scan_sequencer_next_ch.sv
// ---------------------------------------------------------------------------
// adc_scan_next_ch
// Combinational priority picker over the channel enable mask.
//   mask_i   : channel enable mask
//   cur_ch_i : current channel (ignored when first_i is set)
//   first_i  : 1 = pick the lowest set bit overall (frame start),
//              0 = pick the lowest set bit strictly above cur_ch_i
//   next_o   : selected channel
//   found_o  : a channel was selected
// ---------------------------------------------------------------------------
module adc_scan_next_ch
    import adc_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   cur_ch_i,
    input  logic              first_i,
    output logic [CH_W-1:0]   next_o,
    output logic              found_o
);

    // Walk from the top down so the last qualifying hit is the lowest one.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (CH_W'(i) > cur_ch_i))) begin
                next_o  = CH_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
// Walks an enable mask of ADC channels in ascending order, issuing one
// measurement request per channel to the serial reader and waiting for
// completion with a timeout. Results land in an 8-entry register file and
// are strobed out. Scans start from a free-running period timer or a
// one-shot software request.
//   clk, reset_n       : clock, asynchronous active-low reset
//   scan_enable        : enables the period timer
//   scan_req           : one-cycle single-scan request (honoured in IDLE)
//   ch_mask            : channel enable mask, latched at frame start
//   rdr                : reader handshake (master side)
//   sample_*           : per-channel result strobe, channel, data, error flag
//   frame_done         : pulses with the strobe of the last channel
//   overrun            : pulses when a period tick is lost
//   busy               : sequencer not in IDLE
//   rd_ch/rd_data/rd_valid : combinational result-file read port
// ---------------------------------------------------------------------------
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter int PERIOD  = 40000,
    parameter int TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        scan_enable,
    input  logic                        scan_req,
    input  logic [NUM_CH-1:0]           ch_mask,
    adc_scan_sequencer_if.master        rdr,
    output logic                        sample_valid,
    output logic [CH_W-1:0]             sample_ch,
    output logic [DATA_W-1:0]           sample_data,
    output logic                        sample_err,
    output logic                        frame_done,
    output logic                        overrun,
    output logic                        busy,
    input  logic [CH_W-1:0]             rd_ch,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid
);

    scan_state_e       state_q;
    logic [NUM_CH-1:0] mask_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pending_q, pending_d;
    logic              overrun_q;
    logic              start_q;
    logic [CH_W-1:0]   meas_ch_q;
    logic              sample_valid_q, sample_err_q, frame_done_q;
    logic [CH_W-1:0]   sample_ch_q;
    logic [DATA_W-1:0] sample_data_q;
    logic [DATA_W-1:0] result_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q;

    logic              tick, trigger, in_wait, finish_ok, finish_err;
    logic [TMO_W-1:0]  tmo_inc;
    logic              pick_first, pick_found;
    logic [NUM_CH-1:0] pick_mask;
    logic [CH_W-1:0]   pick_ch;

    assign tick       = scan_enable && (timer_q == TMR_W'(PERIOD - 1));
    assign trigger    = (state_q == IDLE) && (pending_q || scan_req);
    assign in_wait    = (state_q == ARM) || (state_q == CONV);
    // A completed conversion wins over a timeout reached in the same cycle.
    assign finish_ok  = (state_q == CONV) && rdr.measure_done;
    assign finish_err = in_wait && (tmo_q == TMO_W'(TIMEOUT)) && !finish_ok;
    assign tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

    // In IDLE the picker looks at the live mask for the frame's first channel;
    // otherwise it looks above the current channel of the latched mask.
    assign pick_first = (state_q == IDLE);
    assign pick_mask  = pick_first ? ch_mask : mask_q;

    adc_scan_next_ch u_next_ch (
        .mask_i   (pick_mask),
        .cur_ch_i (cur_ch_q),
        .first_i  (pick_first),
        .next_o   (pick_ch),
        .found_o  (pick_found)
    );

    // Period timer and pending flag. A fresh tick takes priority over the
    // trigger consuming pending, so a tick is never silently absorbed.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (!scan_enable || tick) begin
            timer_d = '0;
        end
        pending_d = pending_q;
        if (trigger) begin
            pending_d = 1'b0;
        end
        if (tick) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            overrun_q <= tick && pending_q && !trigger;
        end
    end

    // Scan FSM. The channel result is captured on the edge into STORE, so the
    // strobe, frame_done and the result-file update all appear in STORE, and
    // measure_start is low there to guarantee a fresh edge for the next channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            cur_ch_q       <= '0;
            tmo_q          <= '0;
            start_q        <= 1'b0;
            meas_ch_q      <= '0;
            sample_valid_q <= 1'b0;
            sample_err_q   <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
            frame_done_q   <= 1'b0;
            valid_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            if (finish_ok || finish_err) begin
                state_q        <= STORE;
                start_q        <= 1'b0;
                sample_valid_q <= 1'b1;
                sample_ch_q    <= cur_ch_q;
                sample_err_q   <= finish_err;
                sample_data_q  <= finish_ok ? rdr.measure_dataread : '0;
                frame_done_q   <= !pick_found;
                valid_q[cur_ch_q] <= finish_ok;
                if (finish_ok) begin
                    result_q[cur_ch_q] <= rdr.measure_dataread;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (trigger) begin
                            mask_q <= ch_mask;
                            if (pick_found) begin
                                cur_ch_q  <= pick_ch;
                                meas_ch_q <= pick_ch;
                                start_q   <= 1'b1;
                                state_q   <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        tmo_q   <= '0;
                        state_q <= ARM;
                    end
                    // Wait for the reader to drop done from the previous request.
                    ARM: begin
                        tmo_q <= tmo_inc;
                        if (!rdr.measure_done) begin
                            state_q <= CONV;
                        end
                    end
                    CONV: begin
                        tmo_q <= tmo_inc;
                    end
                    STORE: begin
                        if (pick_found) begin
                            cur_ch_q  <= pick_ch;
                            meas_ch_q <= pick_ch;
                            start_q   <= 1'b1;
                            state_q   <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rdr.measure_start = start_q;
    assign rdr.measure_ch    = meas_ch_q;
    assign sample_valid      = sample_valid_q;
    assign sample_ch         = sample_ch_q;
    assign sample_data       = sample_data_q;
    assign sample_err        = sample_err_q;
    assign frame_done        = frame_done_q;
    assign overrun           = overrun_q;
    assign busy              = (state_q != IDLE);
    assign rd_data           = result_q[rd_ch];
    assign rd_valid          = valid_q[rd_ch];

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Channel-scan controller that sits in front of the 8-channel serial ADC reader block and sequences it on behalf of the metering logic. It walks an enable mask of channels in ascending order and, per channel, issues one measurement request and waits for completion with a timeout. Each result is stored in an 8-entry result register file and also emitted as a one-cycle sample strobe. Scans start from a free-running period timer or from a one-shot software request.

## Interface
- `PERIOD`, 40000: scan period in clk cycles (1 kHz at 40 MHz); legal range 2..2^24-1.
- `TIMEOUT`, 1023: maximum clk cycles spent in ARM or CONV before abandoning the channel; legal range 1..2^16-1.

- `clk` in 1: system clock, max 40 MHz, same clock as the ADC reader.
- `reset_n` in 1: asynchronous, active-low reset.
- `scan_enable` in 1: level; enables the period timer.
- `scan_req` in 1: one-cycle pulse; requests a single scan.
- `ch_mask` in 8: channel enable mask, bit i = channel i; latched at frame start.
- `measure_start` out 1: to reader; the reader triggers on the rising edge.
- `measure_ch` out 3: to reader; channel select, stable while `measure_start`=1.
- `measure_done` in 1: from reader; high from end of conversion until the next start edge.
- `measure_dataread` in 12: from reader; valid while `measure_done`=1.
- `sample_valid` out 1: one-cycle strobe per finished channel.
- `sample_ch` out 3: channel of the strobed sample.
- `sample_data` out 12: data of the strobed sample; 0 on timeout.
- `sample_err` out 1: qualifies `sample_valid`; 1 means the channel timed out.
- `frame_done` out 1: one-cycle pulse after the last enabled channel.
- `overrun` out 1: one-cycle pulse when a period tick is lost.
- `busy` out 1: high in every state except IDLE.
- `rd_ch` in 3: result-file read address.
- `rd_data` out 12: combinational read of `result[rd_ch]`.
- `rd_valid` out 1: combinational; valid bit of `rd_ch`.

## Operation
- Reset values:
  - Outputs: all outputs 0; `measure_ch`=0.
  - Internal: state=IDLE; `result[*]`=0; `valid[*]`=0; timer=0; `pending`=0.
- Period timer:
  - Counts 0..`PERIOD`-1 while `scan_enable`=1 and wraps to 0.
  - The wrap cycle is a tick and sets `pending`.
  - When `scan_enable`=0, the timer is held at 0; `pending` is unaffected.
  - A tick while `pending`=1 pulses `overrun`; `pending` stays 1.
- Scan trigger:
  - Trigger = `pending` | `scan_req`, sampled in IDLE only. A `scan_req` outside IDLE is dropped.
  - On trigger:
    - Clear `pending`.
    - Latch `mask_q`=`ch_mask`.
    - Set `cur_ch` = lowest set bit of the mask.
  - If the mask is 0: clear `pending`, stay in IDLE, no `frame_done`.
- State machine:
  - IDLE: on trigger with a nonzero mask -> ISSUE.
  - ISSUE (1 cycle): `measure_start`=1, `measure_ch`=`cur_ch`; clear `tmo_cnt`; -> ARM.
  - ARM: `measure_start` held at 1.
    - `measure_done`=0 -> CONV.
    - `tmo_cnt`=`TIMEOUT` -> STORE with error.
  - CONV: `measure_start` held at 1.
    - `measure_done`=1 -> STORE.
    - `tmo_cnt`=`TIMEOUT` -> STORE with error.
  - STORE (1 cycle): `measure_start`=0.
    - OK path: `result[cur_ch]`=`measure_dataread`, `valid[cur_ch]`=1, `sample_err`=0, `sample_data`=`measure_dataread`.
    - Error path: `valid[cur_ch]`=0, `result` unchanged, `sample_err`=1, `sample_data`=0.
    - Both paths: `sample_valid`=1, `sample_ch`=`cur_ch`.
    - Next channel = lowest set bit of `mask_q` above `cur_ch`. If one exists: `cur_ch`=next, -> ISSUE. If none: `frame_done`=1, -> IDLE.
- `tmo_cnt` is 16 bit, increments every cycle in ARM and CONV, and saturates.
- `measure_start` is low for at least one cycle (STORE or IDLE) between consecutive requests. This guarantees a fresh rising edge at the reader.
- Asserting `reset_n` mid-scan drops `measure_start` to 0 immediately (async), discards the frame, and clears results.

## Timing
- `measure_start` rises in the cycle after the IDLE trigger sample.
- Per-channel latency is the reader's conversion time (≈388 clk cycles) plus 3 cycles (ISSUE, ARM, STORE).
- `sample_valid` and `frame_done` are registered. `frame_done` coincides with the last `sample_valid`.
- `rd_data` and `rd_valid` reflect a STORE write on the cycle after it.

## Structure
- Package `adc_scan_pkg`:
  - Constants: NUM_CH=8, CH_W=3, DATA_W=12, TMO_W=16, TMR_W=24.
  - State encoding: IDLE, ISSUE, ARM, CONV, STORE.
- Sub-module `adc_scan_next_ch`: combinational priority picker (mask, `cur_ch`, first) -> (next, found). It serves both frame-start and STORE selection.

## Test plan
- Single scan: `ch_mask`=0x05, `scan_req`; reader model returns 0x100+ch after 388 cycles.
  - Two strobes: ch0/0x100, then ch2/0x102.
  - `frame_done` together with the second strobe.
  - `rd_ch`=2 gives 0x102 with `rd_valid`=1; `rd_ch`=1 gives `rd_valid`=0.
- Timeout: `TIMEOUT`=50, model never raises done, mask 0x01.
  - Strobe with `sample_err`=1 and `sample_data`=0, 51 cycles after ARM entry.
  - `measure_start` falls; `frame_done` pulses.
- Periodic: `PERIOD`=1000, `scan_enable`=1, mask 0x80.
  - `measure_start` rising edges exactly 1000 cycles apart.
  - `measure_ch`=7 on every request.
- Overrun: `PERIOD`=300, mask 0xFF.
  - `overrun` pulses during the frame.
  - Frames run back-to-back with exactly one pending restart.
- Reset mid-CONV: `reset_n` low for 2 cycles.
  - `measure_start`=0 and `busy`=0 without waiting for a clock edge.
  - `rd_valid`=0 for all channels; no `frame_done`.
- Zero mask: `scan_req` with `ch_mask`=0 -> no `measure_start`, no strobes, `busy` stays 0.
